// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/bubble control for F/D/E/M, load-use and redirect handling, dmem FSM with timeout.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined; otherwise the counter ports read 0.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic [4:0]       D_rs1_i,
    input  logic [4:0]       D_rs2_i,
    input  logic             D_use_rs1_i,
    input  logic             D_use_rs2_i,
    input  logic             E_sel_reg_i,
    input  logic             E_need_dstE_i,
    input  logic [4:0]       E_dstE_i,
    input  logic             E_redirect_i,
    input  logic             M_mem_req_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             E_stall_o,
    output logic             M_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] lu_cnt_o
);
    localparam int TO_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_e;

    state_e          state_q;
    logic [TO_W-1:0] cnt_q;
    logic            mem_err_q;
    logic            mem_wait, load_use, redirect_app, lu_app, run;

    assign run = ~rst && (state_q != S_ERR);

    // In WAIT the access is still outstanding even if the request drops.
    assign mem_wait = ~dmem_ack_i &&
                      (((state_q == S_IDLE) && M_mem_req_i) || (state_q == S_WAIT));

    assign load_use = E_sel_reg_i && E_need_dstE_i && (E_dstE_i != 5'd0) &&
                      ((D_use_rs1_i && (D_rs1_i == E_dstE_i)) ||
                       (D_use_rs2_i && (D_rs2_i == E_dstE_i)));

    assign redirect_app = run && ~mem_wait && E_redirect_i;
    assign lu_app       = run && ~mem_wait && ~E_redirect_i && load_use;
    assign dmem_req_o   = run && M_mem_req_i;
    assign mem_err_o    = mem_err_q;

    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        E_stall_o  = 1'b0;
        M_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        if (rst) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
        end else if (state_q == S_ERR) begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            E_stall_o = 1'b1;
            M_stall_o = 1'b1;
        end else if (mem_wait) begin
            // Memory-stage instruction stays put upstream; writeback sees nops.
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_stall_o  = 1'b1;
            M_bubble_o = 1'b1;
        end else if (redirect_app) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
        end else if (lu_app) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_bubble_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (M_mem_req_i && !dmem_ack_i) begin
                    state_q <= S_WAIT;
                    cnt_q   <= TO_W'(1);
                end
                S_WAIT: if (dmem_ack_i) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end else if (cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
                    state_q   <= S_ERR;
                    mem_err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + TO_W'(1);
                end
                default: state_q <= state_q;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, lu_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d, lu_cnt_d;

    assign stall_cnt_d = stall_cnt_q + CNT_W'(F_stall_o);
    assign flush_cnt_d = flush_cnt_q + CNT_W'(redirect_app);
    assign lu_cnt_d    = lu_cnt_q + CNT_W'(lu_app);

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign lu_cnt_o    = lu_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
    assign lu_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;
    logic        clk_i = 1'b0;
    logic        rst;
    logic [4:0]  D_rs1_i, D_rs2_i, E_dstE_i;
    logic        D_use_rs1_i, D_use_rs2_i, E_sel_reg_i, E_need_dstE_i;
    logic        E_redirect_i, M_mem_req_i, dmem_ack_i;
    logic        dmem_req_o, mem_err_o;
    logic        F_stall_o, D_stall_o, E_stall_o, M_stall_o;
    logic        D_bubble_o, E_bubble_o, M_bubble_o;
    logic [31:0] stall_cnt_o, flush_cnt_o, lu_cnt_o;
    logic [6:0]  ctl;

    int total = 0;
    int bad   = 0;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {F,D,E,M stall, D,E,M bubble}
    localparam logic [6:0] C_RST  = 7'b0000_111;
    localparam logic [6:0] C_NORM = 7'b0000_000;
    localparam logic [6:0] C_LU   = 7'b1100_010;
    localparam logic [6:0] C_RED  = 7'b0000_110;
    localparam logic [6:0] C_MEM  = 7'b1110_001;
    localparam logic [6:0] C_ERR  = 7'b1111_000;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst(rst),
        .D_rs1_i(D_rs1_i), .D_rs2_i(D_rs2_i),
        .D_use_rs1_i(D_use_rs1_i), .D_use_rs2_i(D_use_rs2_i),
        .E_sel_reg_i(E_sel_reg_i), .E_need_dstE_i(E_need_dstE_i), .E_dstE_i(E_dstE_i),
        .E_redirect_i(E_redirect_i), .M_mem_req_i(M_mem_req_i), .dmem_ack_i(dmem_ack_i),
        .dmem_req_o(dmem_req_o),
        .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .E_stall_o(E_stall_o), .M_stall_o(M_stall_o),
        .D_bubble_o(D_bubble_o), .E_bubble_o(E_bubble_o), .M_bubble_o(M_bubble_o),
        .mem_err_o(mem_err_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .lu_cnt_o(lu_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign ctl = {F_stall_o, D_stall_o, E_stall_o, M_stall_o, D_bubble_o, E_bubble_o, M_bubble_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        D_rs1_i = 0; D_rs2_i = 0; E_dstE_i = 0;
        D_use_rs1_i = 0; D_use_rs2_i = 0; E_sel_reg_i = 0; E_need_dstE_i = 0;
        E_redirect_i = 0; M_mem_req_i = 0; dmem_ack_i = 0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        M_mem_req_i = 1'b1;
        #2;
        chk("rst_ctl", 32'(ctl), 32'(C_RST));
        chk("rst_req", 32'(dmem_req_o), 0);
        chk("rst_err", 32'(mem_err_o), 0);
        tick(); tick();
        clr(); rst = 1'b0; #3;
        chk("normal", 32'(ctl), 32'(C_NORM));
        chk("cnt_reset", stall_cnt_o | flush_cnt_o | lu_cnt_o, 0);
        tick();

        // load to x5, decode reads rs1=x5
        E_sel_reg_i = 1; E_need_dstE_i = 1; E_dstE_i = 5; D_use_rs1_i = 1; D_rs1_i = 5; #3;
        chk("lu_rs1", 32'(ctl), 32'(C_LU));
        tick();
        E_sel_reg_i = 0; E_need_dstE_i = 0; #3;
        chk("lu_after", 32'(ctl), 32'(C_NORM));
        tick();
        clr(); E_sel_reg_i = 1; E_need_dstE_i = 1; E_dstE_i = 7; D_use_rs2_i = 1; D_rs2_i = 7; #3;
        chk("lu_rs2", 32'(ctl), 32'(C_LU));
        tick();
        D_use_rs2_i = 0; #3;
        chk("lu_rs2_unused", 32'(ctl), 32'(C_NORM));
        tick();
        clr(); E_sel_reg_i = 1; E_need_dstE_i = 1; E_dstE_i = 0; D_use_rs1_i = 1; D_rs1_i = 0; #3;
        chk("lu_x0", 32'(ctl), 32'(C_NORM));
        tick();
        clr(); E_need_dstE_i = 1; E_dstE_i = 9; D_use_rs1_i = 1; D_rs1_i = 9; #3;
        chk("alu_no_lu", 32'(ctl), 32'(C_NORM));
        chk("lu_cnt2", lu_cnt_o, PERF ? 2 : 0);
        chk("stall_cnt2", stall_cnt_o, PERF ? 2 : 0);
        tick();

        clr(); rst = 1'b1; tick(); rst = 1'b0; #3;
        chk("cnt_clr", stall_cnt_o | lu_cnt_o, 0);
        tick();

        // memory access acked after 3 stall cycles; redirect deferred during wait
        M_mem_req_i = 1; #3;
        chk("mw0", 32'(ctl), 32'(C_MEM));
        chk("mw0_req", 32'(dmem_req_o), 1);
        tick();
        E_redirect_i = 1; #3;
        chk("mw1_redir_deferred", 32'(ctl), 32'(C_MEM));
        tick();
        E_redirect_i = 0; #3;
        chk("mw2", 32'(ctl), 32'(C_MEM));
        tick();
        dmem_ack_i = 1; #3;
        chk("mw3_ack", 32'(ctl), 32'(C_NORM));
        chk("mw3_req", 32'(dmem_req_o), 1);
        tick();
        clr(); #3;
        chk("mw_idle", 32'(ctl), 32'(C_NORM));
        tick();

        // redirect wins over load-use
        E_sel_reg_i = 1; E_need_dstE_i = 1; E_dstE_i = 3; D_use_rs1_i = 1; D_rs1_i = 3; E_redirect_i = 1; #3;
        chk("redir_over_lu", 32'(ctl), 32'(C_RED));
        tick();
        clr(); M_mem_req_i = 1; dmem_ack_i = 1; #3;
        chk("same_cycle_ack", 32'(ctl), 32'(C_NORM));
        tick();
        clr(); #3;
        chk("same_cycle_idle", 32'(ctl), 32'(C_NORM));
        chk("perf_stall", stall_cnt_o, PERF ? 3 : 0);
        chk("perf_flush", flush_cnt_o, PERF ? 1 : 0);
        chk("perf_lu", lu_cnt_o, 0);
        tick();

        // async reset while in WAIT
        M_mem_req_i = 1; tick();
        rst = 1'b1; #1;
        chk("arst_req", 32'(dmem_req_o), 0);
        chk("arst_ctl", 32'(ctl), 32'(C_RST));
        rst = 1'b0; M_mem_req_i = 0; #1;
        chk("arst_idle", 32'(ctl), 32'(C_NORM));
        tick();

        // timeout: 4 waiting cycles then ERR
        M_mem_req_i = 1;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("to_wait%0d", i), 32'(ctl), 32'(C_MEM));
            chk($sformatf("to_err%0d", i), 32'(mem_err_o), 0);
            tick();
        end
        E_redirect_i = 1; #3;
        chk("err_ctl", 32'(ctl), 32'(C_ERR));
        chk("err_flag", 32'(mem_err_o), 1);
        chk("err_req", 32'(dmem_req_o), 0);
        tick();
        clr(); dmem_ack_i = 1; #3;
        chk("err_sticky", 32'(ctl), 32'(C_ERR));
        tick();
        rst = 1'b1; #1;
        chk("err_rst_ctl", 32'(ctl), 32'(C_RST));
        tick();
        clr(); rst = 1'b0; #3;
        chk("err_cleared", 32'(mem_err_o), 0);
        chk("err_normal", 32'(ctl), 32'(C_NORM));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
